// File: rtl/lut_neuron_array_seq.sv
// -----------------------------------------------------------------------------
// lut_neuron_array_seq
//
// Array of N_NEURONS independent LUT neurons. Each neuron owns a truth table
// of 2^IN_BITS entries of OUT_BITS bits that is loaded at runtime through the
// cfg_* port. Lookups flow as a valid/ready stream through one output register.
//
// Ports:
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   cfg_valid/ready   : table-entry write handshake (accepted in EMPTY/LOAD)
//   cfg_neuron/addr   : target neuron and table entry
//   cfg_data          : entry value
//   cfg_commit        : one-cycle pulse ending the load, enters RUN
//   in_valid/ready    : input vector handshake (accepted in RUN only)
//   in_data           : neuron n address = in_data[n*IN_BITS +: IN_BITS]
//   out_valid/ready   : output vector handshake
//   out_data          : neuron n result = out_data[n*OUT_BITS +: OUT_BITS]
//   state_o           : 0 EMPTY, 1 LOAD, 2 RUN, 3 DRAIN
//   wr_count          : accepted writes since last entry to LOAD (saturating)
//
// Table storage is deliberately not reset: after reset the array sits in EMPTY
// and a commit is required before lookups run, so stale contents are only
// used if the controller explicitly re-commits them.
// -----------------------------------------------------------------------------
module lut_neuron_array_seq #(
    parameter int IN_BITS   = 6,
    parameter int OUT_BITS  = 2,
    parameter int N_NEURONS = 4,
    parameter int NID_W     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [NID_W-1:0]              cfg_neuron,
    input  logic [IN_BITS-1:0]            cfg_addr,
    input  logic [OUT_BITS-1:0]           cfg_data,
    input  logic                          cfg_commit,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_NEURONS*OUT_BITS-1:0] out_data,
    output logic [1:0]                    state_o,
    output logic [15:0]                   wr_count
);

    localparam int DEPTH = 2 ** IN_BITS;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                          state_r;
    state_t                          state_nxt_s;
    logic                            cfg_ready_s;
    logic                            in_ready_s;
    logic                            cfg_acc_s;
    logic                            in_acc_s;
    logic                            out_valid_r;
    logic [N_NEURONS*OUT_BITS-1:0]   out_data_r;
    logic [N_NEURONS*OUT_BITS-1:0]   lookup_s;
    logic [15:0]                     wr_count_r;

    assign cfg_acc_s = cfg_valid && cfg_ready_s;
    assign in_acc_s  = in_valid && in_ready_s;

    assign cfg_ready = cfg_ready_s;
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign state_o   = state_r;
    assign wr_count  = wr_count_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and handshake-ready decode.
    always_comb begin
        state_nxt_s = state_r;
        cfg_ready_s = 1'b0;
        in_ready_s  = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                cfg_ready_s = 1'b1;
                // Commit wins over a same-cycle write; the write is still stored.
                if (cfg_commit) begin
                    state_nxt_s = ST_RUN;
                end else if (cfg_valid) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_LOAD: begin
                cfg_ready_s = 1'b1;
                if (cfg_commit) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                in_ready_s = !out_valid_r || out_ready;
                // A reconfiguration request stops intake; the write itself is
                // only accepted once the array is back in LOAD.
                if (cfg_valid) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!out_valid_r) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // Write counter: restarts on every entry into LOAD, saturates at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count_r <= 16'd0;
        end else if ((state_r == ST_DRAIN) && (state_nxt_s == ST_LOAD)) begin
            wr_count_r <= 16'd0;
        end else if (cfg_acc_s) begin
            if (state_r == ST_EMPTY) begin
                wr_count_r <= 16'd1;
            end else if (wr_count_r != 16'hFFFF) begin
                wr_count_r <= wr_count_r + 16'd1;
            end else begin
                wr_count_r <= wr_count_r;
            end
        end else begin
            wr_count_r <= wr_count_r;
        end
    end

    // One distributed RAM per neuron. Writes addressed to a neuron index at or
    // beyond N_NEURONS match no RAM and are silently dropped.
    for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
        logic [OUT_BITS-1:0] mem_r [0:DEPTH-1];

        // Table write port (only reachable in EMPTY/LOAD, never during lookups).
        always_ff @(posedge clk) begin
            if (cfg_acc_s && (cfg_neuron == NID_W'(n))) begin
                mem_r[cfg_addr] <= cfg_data;
            end
        end

        assign lookup_s[n*OUT_BITS +: OUT_BITS] = mem_r[in_data[n*IN_BITS +: IN_BITS]];
    end

    // Output register: load on accept, drop valid on a consume with no accept,
    // otherwise hold (covers backpressure).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (in_acc_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= lookup_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
        end
    end

endmodule

// File: doc/lut_neuron_array_seq.md
Name: lut_neuron_array_seq

Overview:
- Parametrised, registered successor to the single fixed-ROM LogicNet neuron.
- Holds N_NEURONS independent truth tables, each with 2^IN_BITS entries of OUT_BITS bits.
- Tables are loaded at runtime through a config port, so one instance serves any trained layer.
- Lookups run as a valid/ready stream with one register stage; sits between layer N-1 and layer N in the pipelined classifier datapath.

Parameters:
- IN_BITS, 6, input fan-in bits per neuron (table address width).
- OUT_BITS, 2, output bits per neuron.
- N_NEURONS, 4, neurons (channels) in the array.
- NID_W, 2, width of cfg_neuron; must be >= clog2(N_NEURONS), minimum 1.

Ports:
- clk, in, 1, clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- cfg_valid, in, 1, table-entry write request.
- cfg_ready, out, 1, write accepted when cfg_valid && cfg_ready.
- cfg_neuron, in, NID_W, target neuron index.
- cfg_addr, in, IN_BITS, table entry index.
- cfg_data, in, OUT_BITS, entry value.
- cfg_commit, in, 1, one-cycle pulse: end of load, enter RUN.
- in_valid, in, 1, input vector valid.
- in_ready, out, 1, array can accept input.
- in_data, in, N_NEURONS*IN_BITS, neuron n address = in_data[n*IN_BITS +: IN_BITS].
- out_valid, out, 1, output vector valid.
- out_ready, in, 1, downstream accepts.
- out_data, out, N_NEURONS*OUT_BITS, neuron n result = out_data[n*OUT_BITS +: OUT_BITS].
- state_o, out, 2, current state: 0 EMPTY, 1 LOAD, 2 RUN, 3 DRAIN.
- wr_count, out, 16, accepted table writes since last entry to LOAD (saturates at 0xFFFF).

Behaviour:
- Reset (async assert, sync release): state = EMPTY; out_valid = 0; out_data = 0; wr_count = 0; in_ready = 0; cfg_ready = 1.
- Reset does not clear table storage, but tables are untrusted: state is EMPTY and a commit is required before lookups run.
- Reset mid-load or mid-stream drops all in-flight data. No out_valid is produced for inputs accepted before reset.

State machine:
- EMPTY: cfg_ready = 1, in_ready = 0.
  - Accepted write -> LOAD (the write is performed, wr_count = 1).
  - cfg_commit -> RUN.
- LOAD: cfg_ready = 1, in_ready = 0.
  - Each accepted write stores cfg_data into table[cfg_neuron][cfg_addr] at the clock edge and increments wr_count.
  - cfg_commit -> RUN. A write in the same cycle as the commit is performed.
- RUN: cfg_ready = 0; in_ready = !out_valid || out_ready.
  - cfg_valid -> DRAIN. The write is not accepted in RUN.
  - cfg_commit has no effect.
- DRAIN: cfg_ready = 0, in_ready = 0.
  - Waits until out_valid = 0 (the held output is consumed) -> LOAD.
  - wr_count clears to 0 on entry to LOAD from DRAIN.

Datapath:
- Latency is 1: an input accepted at edge k gives out_valid = 1 and out_data = {table[n][addr_n]} after edge k.
- Each output bit is bit-exact with the stored entry; no arithmetic.
- Backpressure: while out_valid && !out_ready, out_data and out_valid hold and in_ready = 0.
- Same-cycle consume and accept (out_valid && out_ready && in_valid) replaces out_data with no bubble, giving full throughput.
- out_valid falls after a consume edge with no new accept.
- cfg_neuron >= N_NEURONS: the write is accepted and counted but discarded (no table changes).
- Table writes never occur in RUN, so read-during-write is impossible.
- Tables are implemented as distributed RAM, one per neuron.

Test Plan:
- Reset then check: state_o = 0, in_ready = 0, out_valid = 0, cfg_ready = 1; in_valid = 1 is ignored and no out_valid occurs.
- Load neuron 0 with entry[0x02] = 2'b00, entry[0x12] = 2'b01, entry[0x3A] = 2'b10, then commit. Input neuron0 addr 0x12 -> out_data[1:0] = 2'b01 one cycle later. Also wr_count = 3 and state_o = 2.
- Load all 4 neurons, 256 writes with value = addr[1:0] ^ neuron, then stream 1000 random vectors with random out_ready. Every out_data must match the model, with no loss or duplication, order preserved, and out_data stable whenever stalled.
- Hold out_ready = 1 with continuous in_valid -> one result per cycle, no bubbles.
- In RUN with out_valid = 1 and out_ready = 0, assert cfg_valid: state -> 3, in_ready = 0. Release out_ready: state -> 1, wr_count = 0, then the write is accepted.
- Assert rst mid-stream with out_valid = 1: out_valid = 0 immediately (async) and state_o = 0. After release and commit without a reload, lookups return the pre-reset table contents.
